// File: rtl/game_round_controller.sv
// game_round_controller
//   Round/session controller that sits beside the game master FSM. It owns the
//   end-of-round pause timer. It tracks score (2-digit BCD), lives and difficulty
//   level. At each round start it supplies a pseudo-random target start position
//   and the target/torpedo velocities. When the session is lost it holds the
//   master FSM in its end state until the player restarts.
//
//   Optional build macro: GAME_ROUND_CONTROLLER_BONUS_LIFE_EN
//     When defined, a win that makes the score ones digit wrap 9->0 awards one
//     extra life, saturating at 3.
//
// Ports:
//   clk                        system clock
//   reset                      asynchronous, active-high reset
//   end_of_game_timer_start    one-cycle pulse from the master FSM at round end
//   game_won                   round outcome, valid in the start-pulse cycle
//   restart_key                player restart request, level-sensitive
//   end_of_game_timer_running  pause active (held high while the session is lost)
//   target_x / target_y        target start position for the next round
//   target_dx                  signed target X velocity
//   torpedo_dy                 signed torpedo Y velocity
//   score                      BCD {tens, ones}
//   lives                      remaining lives
//   level                      current difficulty level
//   game_over                  session lost
module game_round_controller #(
  parameter int unsigned TIMER_CYCLES   = 50000000,
  parameter int unsigned TIMER_WIDTH    = 26,
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned MAX_LEVEL      = 7,
  parameter int unsigned WINS_PER_LEVEL = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       end_of_game_timer_start,
  input  logic       game_won,
  input  logic       restart_key,
  output logic       end_of_game_timer_running,
  output logic [9:0] target_x,
  output logic [9:0] target_y,
  output logic [3:0] target_dx,
  output logic [3:0] torpedo_dy,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [2:0] level,
  output logic       game_over
);

  localparam logic [15:0]            LfsrSeed  = 16'hACE1;
  localparam logic [TIMER_WIDTH-1:0] TimerLoad = TIMER_WIDTH'(TIMER_CYCLES - 1);
  localparam logic [1:0]             LivesRst  = 2'(LIVES_INIT);
  localparam logic [2:0]             MaxLvl    = 3'(MAX_LEVEL);
  localparam logic [2:0]             WinsLvl   = 3'(WINS_PER_LEVEL);

  // Position/velocity reset values follow from the seed at level 0.
  localparam logic [9:0] TxRst  = {1'b0, LfsrSeed[8:0]};
  localparam logic [9:0] TyRst  = {3'b000, LfsrSeed[13:10], 3'b000};
  localparam logic [3:0] DxRst  = LfsrSeed[15] ? 4'hF : 4'h1;
  localparam logic [3:0] TdyRst = 4'hE;

  typedef enum logic [1:0] {StPlay, StPause, StOver} state_e;

  state_e                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   running_q, running_d;
  logic [7:0]             score_q, score_d;
  logic [1:0]             lives_q, lives_d;
  logic [2:0]             level_q, level_d;
  logic [2:0]             streak_q, streak_d;
  logic                   game_over_q, game_over_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [9:0]             tx_q, tx_d;
  logic [9:0]             ty_q, ty_d;
  logic [3:0]             dx_q, dx_d;
  logic [3:0]             tdy_q, tdy_d;

  logic       load_pos;
  logic [3:0] ones, tens;
  logic       score_sat, ones_wrap;
  logic [7:0] score_won;
  logic [2:0] streak_inc;
  logic [3:0] dx_mag;

  // Score increment helpers: 99 saturates, otherwise ones 9 carries into tens.
  always_comb begin
    ones       = score_q[3:0];
    tens       = score_q[7:4];
    score_sat  = (score_q == 8'h99);
    ones_wrap  = (ones == 4'd9) && !score_sat;
    if (score_sat) begin
      score_won = score_q;
    end else if (ones_wrap) begin
      score_won = {tens + 4'd1, 4'd0};
    end else begin
      score_won = {tens, ones + 4'd1};
    end
    streak_inc = streak_q + 3'd1;
  end

  // Session FSM and counters.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    running_d   = running_q;
    score_d     = score_q;
    lives_d     = lives_q;
    level_d     = level_q;
    streak_d    = streak_q;
    game_over_d = game_over_q;
    load_pos    = 1'b0;
    // Fibonacci LFSR, taps 16,14,13,11; free-running.
    lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    unique case (state_q)
      StPlay, StPause: begin
        if (end_of_game_timer_start) begin
          load_pos  = 1'b1;
          timer_d   = TimerLoad;
          running_d = 1'b1;
          state_d   = StPause;
          if (game_won) begin
            score_d = score_won;
            if (streak_inc == WinsLvl) begin
              streak_d = 3'd0;
              if (level_q != MaxLvl) begin
                level_d = level_q + 3'd1;
              end
            end else begin
              streak_d = streak_inc;
            end
`ifdef GAME_ROUND_CONTROLLER_BONUS_LIFE_EN
            if (ones_wrap && (lives_q != 2'd3)) begin
              lives_d = lives_q + 2'd1;
            end
`endif
          end else begin
            streak_d = 3'd0;
            if (lives_q <= 2'd1) begin
              lives_d     = 2'd0;
              game_over_d = 1'b1;
              state_d     = StOver;
            end else begin
              lives_d = lives_q - 2'd1;
            end
          end
        end else if (state_q == StPause) begin
          if (timer_q == '0) begin
            running_d = 1'b0;
            state_d   = StPlay;
          end else begin
            timer_d = timer_q - TIMER_WIDTH'(1);
          end
        end
      end
      StOver: begin
        // Running stays high so the master FSM waits in its lost-end state.
        running_d = 1'b1;
        if (restart_key) begin
          state_d     = StPlay;
          running_d   = 1'b0;
          timer_d     = '0;
          score_d     = 8'h00;
          lives_d     = LivesRst;
          level_d     = 3'd0;
          streak_d    = 3'd0;
          game_over_d = 1'b0;
          load_pos    = 1'b1;
        end
      end
      default: begin
        state_d = StPlay;
      end
    endcase
  end

  // Round-start position/velocity, computed from the level taking effect.
  always_comb begin
    tx_d   = tx_q;
    ty_d   = ty_q;
    dx_d   = dx_q;
    tdy_d  = tdy_q;
    dx_mag = {1'b0, level_d} + 4'd1;
    if (load_pos) begin
      tx_d  = {1'b0, lfsr_q[8:0]};
      ty_d  = {3'b000, lfsr_q[13:10], 3'b000};
      dx_d  = lfsr_q[15] ? (4'd0 - dx_mag) : dx_mag;
      tdy_d = 4'd0 - (4'd2 + {2'b00, level_d[2:1]});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StPlay;
      timer_q     <= '0;
      running_q   <= 1'b0;
      score_q     <= 8'h00;
      lives_q     <= LivesRst;
      level_q     <= 3'd0;
      streak_q    <= 3'd0;
      game_over_q <= 1'b0;
      lfsr_q      <= LfsrSeed;
      tx_q        <= TxRst;
      ty_q        <= TyRst;
      dx_q        <= DxRst;
      tdy_q       <= TdyRst;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      running_q   <= running_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      streak_q    <= streak_d;
      game_over_q <= game_over_d;
      lfsr_q      <= lfsr_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      dx_q        <= dx_d;
      tdy_q       <= tdy_d;
    end
  end

  assign end_of_game_timer_running = running_q;
  assign target_x                  = tx_q;
  assign target_y                  = ty_q;
  assign target_dx                 = dx_q;
  assign torpedo_dy                = tdy_q;
  assign score                     = score_q;
  assign lives                     = lives_q;
  assign level                     = level_q;
  assign game_over                 = game_over_q;

endmodule
